// File: rtl/counter_16_ctrl.sv
// -----------------------------------------------------------------------------
// counter_16_ctrl
//
// Purpose:
//   Arbitrates two requesters (A and B) for a shared 16-bit up/down counter
//   and sequences one counter operation per grant. Each operation is a
//   parallel load of the requester's preload value, followed by LEN cycles
//   of counting in the requester's mode, followed by a one-cycle completion
//   pulse back to the owner.
//
//   Sequence per operation:
//     IDLE --(any REQ)--> LOAD --> RUN x LEN --> DONE --> IDLE
//     LOAD goes straight to DONE when LEN is zero or the requested mode is
//     itself a parallel load (nothing meaningful to run).
//
//   Arbitration is round-robin. On a simultaneous request the requester that
//   was not served most recently wins; a lone requester always wins. After
//   reset, B is marked as last served, so A wins the first tie.
//
// Handshake:
//   REQ_x is a level request sampled only in IDLE. The grant is implicit: the
//   edge that leaves IDLE latches the winner's CMD/DATA/LEN and raises GNT_x
//   for LOAD, RUN and DONE. DONE_x pulses for exactly one cycle at the end.
//   Dropping REQ_x after the grant edge does not abort the operation; holding
//   it high after DONE_x requests another operation.
//
// Configuration:
//   COUNTER_CTRL_RCO_STOP_EN - when defined, RCO=1 during RUN ends the run
//   early (DONE follows on the next edge). When undefined, RCO is ignored and
//   RUN always lasts LEN cycles.
//
// Parameters:
//   DATA_W  width of the counter data bus (default 16)
//   CNT_W   width of the run-length fields (default 8)
//
// Ports:
//   CLK            in   1       clock, rising edge active
//   RESET          in   1       asynchronous, active-high reset
//   REQ_A, REQ_B   in   1       operation request from A / B
//   CMD_A, CMD_B   in   2       counter mode for the run phase
//   DATA_A, DATA_B in   DATA_W  preload value for the counter
//   LEN_A, LEN_B   in   CNT_W   run length in cycles
//   RCO            in   1       terminal-count flag from the counter
//   ENB            out  1       counter enable
//   MODO           out  2       counter mode: 00 up 1, 01 down 1,
//                               10 down 3, 11 parallel load of D
//   D              out  DATA_W  counter load data (valid in LOAD)
//   GNT_A, GNT_B   out  1       requester currently owns the counter
//   DONE_A, DONE_B out  1       one-cycle completion pulse
//   BUSY           out  1       FSM is not in IDLE
// -----------------------------------------------------------------------------
module counter_16_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [1:0]        CMD_A,
  input  logic [1:0]        CMD_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
  input  logic [CNT_W-1:0]  LEN_A,
  input  logic [CNT_W-1:0]  LEN_B,
  input  logic              RCO,
  output logic              ENB,
  output logic [1:0]        MODO,
  output logic [DATA_W-1:0] D,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              DONE_A,
  output logic              DONE_B,
  output logic              BUSY
);

  // ---------------------------------------------------------------------------
  // Mode encoding driven onto MODO
  // ---------------------------------------------------------------------------
  localparam logic [1:0] MODE_UP1   = 2'b00;
  localparam logic [1:0] MODE_DOWN1 = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;

  // Fields latched from the winning requester on the grant edge.
  logic [1:0]         cmd_q;
  logic [DATA_W-1:0]  data_q;

  // Remaining RUN cycles; loaded with LEN on the grant edge.
  logic [CNT_W-1:0]   cnt_q;

  // Owner of the current operation: 0 = A, 1 = B.
  logic               owner_b_q;

  // Round-robin pointer: 1 when B was served most recently.
  logic               last_b_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic               req_any;
  logic               pick_b;
  logic               grant_now;

  assign req_any = REQ_A | REQ_B;

  // B wins when it asks alone, or when both ask and A was served last.
  assign pick_b  = REQ_B & (~REQ_A | ~last_b_q);

  assign grant_now = (state_q == S_IDLE) & req_any;

  // ---------------------------------------------------------------------------
  // Early-stop source
  // ---------------------------------------------------------------------------
  logic               rco_stop;

`ifdef COUNTER_CTRL_RCO_STOP_EN
  assign rco_stop = RCO;
`else
  // RCO has no effect in this build; keep it visibly consumed.
  logic               rco_unused;
  assign rco_unused = RCO;
  assign rco_stop   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Decodes of the latched operation
  // ---------------------------------------------------------------------------
  logic               skip_run;
  logic               run_last;

  // Nothing to run for a zero length or for a load-only command.
  assign skip_run = (cnt_q == '0) | (cmd_q == MODE_LOAD);

  // The cycle in which RUN ends: last counted cycle, or early stop.
  assign run_last = (cnt_q == CNT_W'(1)) | rco_stop;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (skip_run) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched request fields, run counter and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_q     <= MODE_UP1;
      data_q    <= '0;
      cnt_q     <= '0;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      if (grant_now) begin
        owner_b_q <= pick_b;
        last_b_q  <= pick_b;
        if (pick_b) begin
          cmd_q  <= CMD_B;
          data_q <= DATA_B;
          cnt_q  <= LEN_B;
        end else begin
          cmd_q  <= CMD_A;
          data_q <= DATA_A;
          cnt_q  <= LEN_A;
        end
      end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the state register only, so they are glitch-free
  // with respect to the request inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    ENB    = 1'b0;
    MODO   = MODE_UP1;
    D      = '0;
    GNT_A  = 1'b0;
    GNT_B  = 1'b0;
    DONE_A = 1'b0;
    DONE_B = 1'b0;
    BUSY   = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // all outputs idle
      end
      S_LOAD: begin
        ENB   = 1'b1;
        MODO  = MODE_LOAD;
        D     = data_q;
        GNT_A = ~owner_b_q;
        GNT_B = owner_b_q;
      end
      S_RUN: begin
        ENB   = 1'b1;
        MODO  = cmd_q;
        GNT_A = ~owner_b_q;
        GNT_B = owner_b_q;
      end
      S_DONE: begin
        GNT_A  = ~owner_b_q;
        GNT_B  = owner_b_q;
        DONE_A = ~owner_b_q;
        DONE_B = owner_b_q;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  // Mode constants that only appear as values of the latched command.
  logic mode_consts_unused;
  assign mode_consts_unused = ^{MODE_DOWN1, MODE_DOWN3};

endmodule

// File: tb/tb_counter_16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_16_ctrl
//
// Self-checking bench for counter_16_ctrl. A behavioural 16-bit counter is
// attached to ENB/MODO/D and drives RCO (high when the count is zero). For
// every operation the reference model derives, from the grant rules and the
// counter arithmetic, the list of per-cycle output vectors the controller
// should produce and pushes them into exp_q; the driver then steps the clock
// and compares the DUT against each entry.
// -----------------------------------------------------------------------------
module tb_counter_16_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int VW     = 1 + 2 + DATA_W + 5;

  // Vector layout: {ENB, MODO, D, GNT_A, GNT_B, DONE_A, DONE_B, BUSY}
  localparam logic [VW-1:0] ALL_MASK = {VW{1'b1}};
  localparam logic [VW-1:0] D_MASK   = {1'b1, 2'b11, {DATA_W{1'b0}}, 5'b11111};

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              REQ_A = 1'b0;
  logic              REQ_B = 1'b0;
  logic [1:0]        CMD_A = 2'b00;
  logic [1:0]        CMD_B = 2'b00;
  logic [DATA_W-1:0] DATA_A = '0;
  logic [DATA_W-1:0] DATA_B = '0;
  logic [CNT_W-1:0]  LEN_A = '0;
  logic [CNT_W-1:0]  LEN_B = '0;
  logic              RCO;
  logic              ENB;
  logic [1:0]        MODO;
  logic [DATA_W-1:0] D;
  logic              GNT_A;
  logic              GNT_B;
  logic              DONE_A;
  logic              DONE_B;
  logic              BUSY;

  always #5 CLK = ~CLK;

  counter_16_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .REQ_A  (REQ_A),
    .REQ_B  (REQ_B),
    .CMD_A  (CMD_A),
    .CMD_B  (CMD_B),
    .DATA_A (DATA_A),
    .DATA_B (DATA_B),
    .LEN_A  (LEN_A),
    .LEN_B  (LEN_B),
    .RCO    (RCO),
    .ENB    (ENB),
    .MODO   (MODO),
    .D      (D),
    .GNT_A  (GNT_A),
    .GNT_B  (GNT_B),
    .DONE_A (DONE_A),
    .DONE_B (DONE_B),
    .BUSY   (BUSY)
  );

  // ---------------------------------------------------------------------------
  // Shared counter driven by the controller
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ctr = '0;

  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b00:   ctr <= ctr + 16'd1;
        2'b01:   ctr <= ctr - 16'd1;
        2'b10:   ctr <= ctr - 16'd3;
        default: ctr <= D;
      endcase
    end
  end

  assign RCO = (ctr == '0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int              n_vec = 0;
  int              n_err = 0;
  logic [VW-1:0]   exp_q[$];
  logic [VW-1:0]   msk_q[$];
  bit              last_b = 1'b1;   // model: B served most recently

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk(input bit enb, input logic [1:0] modo,
                                       input logic [DATA_W-1:0] d, input bit ga,
                                       input bit gb, input bit da, input bit db,
                                       input bit busy);
    return {enb, modo, d, ga, gb, da, db, busy};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {ENB, MODO, D, GNT_A, GNT_B, DONE_A, DONE_B, BUSY};
  endfunction

  // Counter arithmetic for one enabled cycle in a counting mode.
  function automatic logic [DATA_W-1:0] next_val(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] cmd);
    case (cmd)
      2'b00:   return v + 16'd1;
      2'b01:   return v - 16'd1;
      default: return v - 16'd3;
    endcase
  endfunction

  // Number of RUN cycles an operation should take.
  function automatic int run_cycles(input logic [1:0] cmd, input logic [DATA_W-1:0] data,
                                    input logic [CNT_W-1:0] len);
    logic [DATA_W-1:0] v;
    if (len == 0 || cmd == 2'b11) return 0;
    v = data;
`ifdef COUNTER_CTRL_RCO_STOP_EN
    for (int k = 1; k <= int'(len); k++) begin
      if (v == '0) return k;
      v = next_val(v, cmd);
    end
`endif
    return int'(len);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Call in an IDLE cycle with at least one REQ high. Predicts the winner,
  // queues the full output trace, steps through it and drops the winner's REQ
  // either during LOAD or one cycle later.
  task automatic serve_one(input bit late_drop, input string tag);
    bit                win_b;
    bit                ga;
    bit                gb;
    logic [1:0]        c;
    logic [DATA_W-1:0] dd;
    logic [CNT_W-1:0]  ln;
    int                nr;
    int                n;
    logic [VW-1:0]     e;
    logic [VW-1:0]     m;

    win_b  = (REQ_A && REQ_B) ? !last_b : REQ_B;
    last_b = win_b;
    c      = win_b ? CMD_B  : CMD_A;
    dd     = win_b ? DATA_B : DATA_A;
    ln     = win_b ? LEN_B  : LEN_A;
    ga     = !win_b;
    gb     = win_b;
    nr     = run_cycles(c, dd, ln);

    exp_q.push_back(mk(1, 2'b11, dd, ga, gb, 0, 0, 1));
    msk_q.push_back(ALL_MASK);
    for (int i = 0; i < nr; i++) begin
      exp_q.push_back(mk(1, c, '0, ga, gb, 0, 0, 1));
      msk_q.push_back(D_MASK);
    end
    exp_q.push_back(mk(0, 2'b00, '0, ga, gb, ga, gb, 1));
    msk_q.push_back(ALL_MASK);
    exp_q.push_back(mk(0, 2'b00, '0, 0, 0, 0, 0, 0));
    msk_q.push_back(ALL_MASK);

    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      if ((i == 0 && !late_drop) || (i == 1 && late_drop)) begin
        if (win_b) REQ_B = 1'b0;
        else       REQ_A = 1'b0;
      end
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      check(tag, 32'(obs_vec() & m), 32'(e & m));
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'(obs_vec()), 32'(0));
    RESET  = 1'b0;
    last_b = 1'b1;
    exp_q.delete();
    msk_q.delete();
    tick();
    check("idle_after_reset", 32'(obs_vec()), 32'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    do_reset();

    // Simultaneous requests after reset: A first, then B after one IDLE cycle.
    CMD_A = 2'b00; DATA_A = 16'h0100; LEN_A = 8'd3;
    CMD_B = 2'b01; DATA_B = 16'h0200; LEN_B = 8'd2;
    REQ_A = 1'b1;  REQ_B = 1'b1;
    serve_one(0, "pair1_first");
    serve_one(0, "pair1_second");

    // A alone, then a tie again: B was not served most recently -> B first.
    CMD_A = 2'b10; DATA_A = 16'h0030; LEN_A = 8'd1;
    REQ_A = 1'b1;
    serve_one(0, "a_single");
    CMD_A = 2'b00; DATA_A = 16'h0400; LEN_A = 8'd2;
    CMD_B = 2'b10; DATA_B = 16'h0500; LEN_B = 8'd3;
    REQ_A = 1'b1;  REQ_B = 1'b1;
    serve_one(0, "pair2_first");
    serve_one(0, "pair2_second");

    // Count up 5 from 0x0010.
    CMD_A = 2'b00; DATA_A = 16'h0010; LEN_A = 8'd5;
    REQ_A = 1'b1;
    serve_one(0, "a_up5");
    check("ctr_end", 32'(ctr), 32'h0015);

    // Zero length, load command: LOAD then DONE.
    CMD_B = 2'b11; DATA_B = 16'hBEEF; LEN_B = 8'd0;
    REQ_B = 1'b1;
    serve_one(0, "b_len0");
    check("ctr_after_load_only", 32'(ctr), 32'hBEEF);

    // Count down from 2 for 10 cycles (early stop on RCO when enabled).
    CMD_A = 2'b01; DATA_A = 16'h0002; LEN_A = 8'd10;
    REQ_A = 1'b1;
    serve_one(0, "a_rco");

    // Request dropped in the first RUN cycle.
    CMD_A = 2'b10; DATA_A = 16'h0100; LEN_A = 8'd4;
    REQ_A = 1'b1;
    serve_one(1, "a_drop");

    // Reset in the middle of RUN: asynchronous return to idle, no DONE.
    CMD_A = 2'b00; DATA_A = 16'h0040; LEN_A = 8'd20;
    REQ_A = 1'b1;
    tick();
    REQ_A = 1'b0;
    check("midrst_load", 32'(obs_vec()), 32'(mk(1, 2'b11, 16'h0040, 1, 0, 0, 0, 1)));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_run", 32'(obs_vec() & D_MASK), 32'(mk(1, 2'b00, '0, 1, 0, 0, 0, 1) & D_MASK));
    end
    #3;
    RESET = 1'b1;
    #1;
    check("midrst_async", 32'(obs_vec()), 32'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_held", 32'(obs_vec()), 32'(0));
    end
    RESET  = 1'b0;
    last_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 32'(obs_vec()), 32'(0));
    end

    // Tie right after an aborted operation: pointer is back to A-first.
    CMD_A = 2'b01; DATA_A = 16'h0900; LEN_A = 8'd2;
    CMD_B = 2'b00; DATA_B = 16'h0A00; LEN_B = 8'd1;
    REQ_A = 1'b1;  REQ_B = 1'b1;
    serve_one(0, "post_rst_first");
    serve_one(0, "post_rst_second");

    // Randomized operations.
    for (int it = 0; it < 40; it++) begin
      int sel;
      bit late;
      sel    = $urandom_range(1, 3);
      late   = 1'($urandom_range(0, 1));
      CMD_A  = 2'($urandom_range(0, 3));
      CMD_B  = 2'($urandom_range(0, 3));
      DATA_A = 16'($urandom);
      DATA_B = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      LEN_A  = 8'($urandom_range(0, 12));
      LEN_B  = 8'($urandom_range(0, 12));
      REQ_A  = sel[0];
      REQ_B  = sel[1];
      while (REQ_A || REQ_B) begin
        serve_one(late, "random_op");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_16_ctrl.md
COUNTER_16_CTRL -- requirements
Module: counter_16_ctrl

Interface
REQ-001 The block SHALL expose the parameter DATA_W, default 16, as the width of the counter data bus.
REQ-002 The block SHALL expose the parameter CNT_W, default 8, as the width of the run-length fields.
REQ-003 The block SHALL have these ports, one per line (name  direction  width  meaning):
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_A, REQ_B  in  1  operation request from requester A or B.
- CMD_A, CMD_B  in  2  requested counter mode for the run phase.
- DATA_A, DATA_B  in  DATA_W  preload value for the counter.
- LEN_A, LEN_B  in  CNT_W  run length in cycles.
- RCO  in  1  terminal-count flag from the shared 16-bit counter.
- ENB  out  1  counter enable.
- MODO  out  2  counter mode.
- D  out  DATA_W  counter load data.
- GNT_A, GNT_B  out  1  requester currently owns the counter.
- DONE_A, DONE_B  out  1  one-cycle completion pulse.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-004 MODO encoding SHALL be: 00 count up by 1, 01 count down by 1, 10 count down by 3, 11 parallel load of D.
REQ-005 The FSM SHALL have four states, IDLE, LOAD, RUN and DONE; the state register SHALL be the only sequencing state besides the latched request fields.
REQ-006 In IDLE with at least one REQ high, the next edge SHALL enter LOAD and latch the winner's CMD, DATA and LEN; requests SHALL be ignored outside IDLE.
REQ-007 Arbitration SHALL be round-robin: if both REQ are high, the requester not served most recently wins; a single requester SHALL always win.
REQ-008 In LOAD (exactly 1 cycle), the outputs SHALL be ENB=1, MODO=11 and D=latched DATA.
REQ-009 In RUN, the outputs SHALL be ENB=1 and MODO=latched CMD for exactly LEN cycles, using a down-counter loaded with LEN; RUN SHALL exit to DONE when the remaining count is 1.
REQ-010 If LEN=0 or the latched CMD=11, LOAD SHALL go directly to DONE with no RUN cycles.
REQ-011 In DONE (exactly 1 cycle), ENB SHALL be 0 and the owner's DONE_x SHALL be 1; the next state SHALL be IDLE.
REQ-012 GNT_x SHALL be high from LOAD through DONE inclusive for the owner only; GNT_A and GNT_B SHALL never be high together.
REQ-013 In IDLE and DONE, the outputs SHALL be ENB=0, MODO=00 and D=0.
REQ-014 Deasserting the owner's REQ mid-operation SHALL NOT abort the operation.
REQ-015 The minimum request-to-DONE latency SHALL be LOAD + LEN + 1 cycles after the latching edge; the back-to-back gap SHALL be one IDLE cycle.

Reset
REQ-016 Asserting RESET SHALL immediately force IDLE, with ENB=0, MODO=00, D=0, all GNT_x and DONE_x low, BUSY=0 and the run counter cleared, regardless of CLK.
REQ-017 After reset, the round-robin pointer SHALL mark B as last served, so A wins the first simultaneous request.
REQ-018 Reset asserted mid-operation SHALL abort the operation with no DONE pulse.

Configuration
REQ-019 Macro COUNTER_CTRL_RCO_STOP_EN: when defined, RCO=1 sampled during RUN SHALL end RUN early and enter DONE on the next edge; when undefined, RCO SHALL be ignored and RUN SHALL always last LEN cycles.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset pulse mid-RUN -> all outputs return to reset values asynchronously, no DONE_A or DONE_B pulse.
- REQ_A only, CMD_A=00, DATA_A=16'h0010, LEN_A=5 -> LOAD with D=16'h0010 and MODO=11, then 5 cycles of ENB=1 with MODO=00, then one DONE_A pulse; the counter ends at 16'h0015.
- REQ_A and REQ_B both high after reset -> A is granted first, B is granted after A's DONE plus one IDLE cycle; repeating the test grants B first.
- REQ_B with LEN_B=0 and CMD_B=11 -> sequence is LOAD then DONE_B, with no RUN cycles.
- With COUNTER_CTRL_RCO_STOP_EN defined, CMD_A=01, DATA_A=16'h0002, LEN_A=10 -> RUN ends when RCO rises at count 0 and DONE_A follows early; with the macro undefined, all 10 RUN cycles execute.
- REQ_A dropped in the cycle after LOAD -> the operation completes and DONE_A still pulses.
